// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker: FSM state, Galois LFSR step and popcount.
// Helpers work on a MAX_LEN-wide zero-padded word so any LEN up to MAX_LEN can use them.
package prbs_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int unsigned MAX_LEN = 64;

    typedef logic [MAX_LEN-1:0] word_t;

    // Upper bits above LEN are zero, so a plain right shift equals {1'b0, x[LEN-1:1]}.
    function automatic word_t lfsr_step(input word_t x, input word_t taps);
        return (x >> 1) ^ (x[0] ? taps : '0);
    endfunction

    function automatic int unsigned popcount(input word_t x);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            n = n + {31'b0, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Data and statistics bundle of the PRBS checker; master drives received words, slave reports.
interface prbs_checker_if #(
    parameter int unsigned LEN   = 8,
    parameter int unsigned CNT_W = 32
);
    logic             en;
    logic             clear;
    logic [LEN-1:0]   din;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_err_cnt;
    logic [CNT_W-1:0] bit_err_cnt;

    modport master (
        output en, clear, din,
        input  locked, err_pulse, word_cnt, word_err_cnt, bit_err_cnt
    );

    modport slave (
        input  en, clear, din,
        output locked, err_pulse, word_cnt, word_err_cnt, bit_err_cnt
    );
endinterface

// File: rtl/prbs_popcount.sv
// Combinational bit counter for the mismatch vector; isolates the bit-error adder input path.
module prbs_popcount
    import prbs_pkg::*;
#(
    parameter  int unsigned LEN = 8,
    localparam int unsigned CW  = $clog2(LEN + 1)
) (
    input  logic [LEN-1:0] bits,
    output logic [CW-1:0]  count
);

    assign count = CW'(popcount(word_t'(bits)));

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS word checker: hunts for lock by seeding from din, then free-runs
// its own Galois LFSR and accumulates saturating word/bit error statistics.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned    LEN        = 8,
    parameter logic [LEN-1:0] TAPS       = 8'b10111000,
    parameter int unsigned    LOCK_CNT   = 4,
    parameter int unsigned    UNLOCK_CNT = 4,
    parameter int unsigned    CNT_W      = 32
) (
    input logic           clk,
    input logic           rst_n,
    prbs_checker_if.slave bus
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned PW = $clog2(LEN + 1);
    localparam word_t       TAPS_W = word_t'(TAPS);

    state_e           state_q, state_d;
    logic [LEN-1:0]   exp_q, exp_d;
    logic             has_prev_q, has_prev_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [UW-1:0]    miss_cnt_q, miss_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] word_err_cnt_q, word_err_cnt_d;
    logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;

    logic [LEN-1:0]   step_din, step_exp, diff;
    logic [PW-1:0]    diff_bits;
    logic [CNT_W:0]   bit_sum;
    logic             hunt_match, word_err;

    assign step_din   = LEN'(lfsr_step(word_t'(bus.din), TAPS_W));
    assign step_exp   = LEN'(lfsr_step(word_t'(exp_q), TAPS_W));
    assign diff       = bus.din ^ exp_q;
    assign word_err   = (diff != '0);
    // An all-zero word is the LFSR lock-up state and must never count toward lock.
    assign hunt_match = has_prev_q && !word_err && (bus.din != '0);

    prbs_popcount #(
        .LEN(LEN)
    ) u_popcount (
        .bits (diff),
        .count(diff_bits)
    );

    // One extra bit catches overflow so the sum can saturate instead of wrapping.
    assign bit_sum = {1'b0, bit_err_cnt_q} + (CNT_W + 1)'(diff_bits);

    always_comb begin
        state_d        = state_q;
        exp_d          = exp_q;
        has_prev_d     = has_prev_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        err_pulse_d    = 1'b0;
        word_cnt_d     = word_cnt_q;
        word_err_cnt_d = word_err_cnt_q;
        bit_err_cnt_d  = bit_err_cnt_q;

        if (bus.en) begin
            unique case (state_q)
                HUNT: begin
                    exp_d      = step_din;
                    has_prev_d = 1'b1;
                    if (hunt_match) begin
                        if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
                            state_d     = LOCKED;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d      = step_exp;
                    word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CNT_W'(1);
                    if (word_err) begin
                        err_pulse_d    = 1'b1;
                        word_err_cnt_d = (word_err_cnt_q == '1) ? word_err_cnt_q
                                                                : word_err_cnt_q + CNT_W'(1);
                        bit_err_cnt_d  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                        miss_cnt_d     = miss_cnt_q + UW'(1);
                        if (miss_cnt_q == UW'(UNLOCK_CNT - 1)) begin
                            state_d     = HUNT;
                            has_prev_d  = 1'b0;
                            match_cnt_d = '0;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        // Clear overrides any same-cycle contribution; lock state and err_pulse are unaffected.
        if (bus.clear) begin
            word_cnt_d     = '0;
            word_err_cnt_d = '0;
            bit_err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HUNT;
            exp_q          <= '0;
            has_prev_q     <= 1'b0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            err_pulse_q    <= 1'b0;
            word_cnt_q     <= '0;
            word_err_cnt_q <= '0;
            bit_err_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            exp_q          <= exp_d;
            has_prev_q     <= has_prev_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            err_pulse_q    <= err_pulse_d;
            word_cnt_q     <= word_cnt_d;
            word_err_cnt_q <= word_err_cnt_d;
            bit_err_cnt_q  <= bit_err_cnt_d;
        end
    end

    assign bus.locked       = (state_q == LOCKED);
    assign bus.err_pulse    = err_pulse_q;
    assign bus.word_cnt     = word_cnt_q;
    assign bus.word_err_cnt = word_err_cnt_q;
    assign bus.bit_err_cnt  = bit_err_cnt_q;

endmodule
